timer_bank: RTL and testbench
=============================

Name: timer_bank

Overview:
- Parametrised successor to the single free-running ticks counter on the J1 I/O bus.
- Provides NCH independent WIDTH-bit timers. Each timer has its own prescaler, compare register and one of three modes: free-run, periodic or one-shot.
- Per-channel pending flags are write-1-to-clear; a registered, masked OR of them drives the J1 interrupt_request.
- Sits on the io_rd/io_wr/io_addr bus. The top-level one-hot address decode supplies the chip select.

Parameters:
- WIDTH, 16, counter, compare and data width (≥ 8).
- NCH, 2, number of timer channels (1..8).
- PSW, 8, prescaler width in bits.
- AW, 5, register address width; 2^AW ≥ 4*(NCH+1).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- sel  in  1  chip select from top-level io_addr decode.
- addr  in  AW  register index: {channel, reg[1:0]}; channel==NCH is the global bank.
- rd  in  1  read strobe (qualified by sel).
- wr  in  1  write strobe (qualified by sel).
- wdata  in  WIDTH  write data.
- rdata  out  WIDTH  read data; 0 when !(sel&rd), so it can be ORed onto io_din.
- irq  out  1  interrupt request (registered).
- pending  out  NCH  raw pending flags, for debug and LEDs.

Behaviour:
- Register map, channel c (reg index):
  - 0 COUNT: read/write.
  - 1 COMPARE: read/write.
  - 2 CTRL: bit0 EN, bits2:1 MODE, bit3 IE; other bits read 0.
  - 3 PRESCALE: read/write, low PSW bits; upper bits read 0.
- Register map, global bank (channel NCH):
  - reg 0 STATUS: read = pending zero-extended; write = clear bits where wdata=1.
  - reg 1 IEALL: read = concatenated IE bits; writes ignored.
  - regs 2-3, and any unmapped index: read 0, writes ignored.
- Reset: all COUNT, COMPARE, CTRL, PRESCALE, prescaler counters, pending and irq become 0.
- Prescaler (per channel):
  - Runs only while EN=1.
  - A tick is a cycle with EN=1 and pcnt==PRESCALE; that cycle pcnt<=0, otherwise pcnt<=pcnt+1.
  - PRESCALE=0 gives a tick every cycle; PRESCALE=P gives a tick every P+1 cycles.
- Counter on a tick, by MODE:
  - MODE 0 free-run: COUNT<=COUNT+1, wraps from all-ones to 0. Event = the wrap. This is identical to the legacy ticks overflow.
  - MODE 1 periodic: if COUNT==COMPARE then COUNT<=0 and event; else COUNT+1 (wraps silently with no event if COUNT>COMPARE).
  - MODE 2 one-shot: as MODE 1, but on the event also EN<=0 and COUNT holds at 0.
  - MODE 3: reserved, behaves as MODE 0.
- Event: pending[c]<=1 on the clock edge ending the event cycle, independent of IE.
- irq <= |(pending & IE) registered, so irq rises 1 cycle after pending rises and falls 1 cycle after the last qualifying pending clears or its IE drops.
- Writes (sel&wr) take effect at the clock edge.
  - COUNT write overrides any same-cycle tick or increment, and reloads pcnt<=0.
  - CTRL write with EN 0→1 reloads pcnt<=0.
  - CTRL write with EN=0 freezes COUNT and pcnt.
- STATUS write with a same-cycle event on the same channel: the set wins and pending stays 1.
- Reads are combinational from addr, with no side effects; rdata=0 whenever sel=0 or rd=0.
- rd and wr in the same cycle: the read returns the pre-write value.
- reset asserted mid-count returns everything to reset state on the next edge; no event is generated by reset.
- Channels are fully independent. Simultaneous events on several channels each set their own pending bit.

Test Plan:
- Reset/readback:
  - Stimulus: assert reset, then read all registers; write and read back COMPARE=0x1234 and PRESCALE=0x1FF.
  - Required: all reset reads return 0. COMPARE reads 0x1234. PRESCALE reads 0x00FF, truncated to PSW.
- Free-run wrap:
  - Stimulus: ch0 COUNT=0xFFFD, PRESCALE=0, CTRL=EN|IE (MODE 0).
  - Required: COUNT reads 0xFFFE, 0xFFFF, then 0x0000. pending[0] is set on the wrap edge; irq goes high one cycle later.
- Periodic with prescaler:
  - Stimulus: ch1 COMPARE=3, PRESCALE=2, MODE 1, EN.
  - Required: COUNT steps every 3 cycles 0,1,2,3,0. An event occurs every 12 cycles; pending[1] stays set with IE=0 and irq stays 0.
- One-shot:
  - Stimulus: ch0 MODE 2, COMPARE=5, PRESCALE=0, EN|IE.
  - Required: after 6 ticks, pending[0]=1 and CTRL.EN reads 0. COUNT holds 0 for 20 further cycles.
- W1C race:
  - Stimulus: write STATUS=0x1 in the exact cycle ch0 generates an event.
  - Required: pending[0] remains 1. A later STATUS=0x1 write clears it; irq drops one cycle afterwards.
- Bus isolation:
  - Stimulus: rd=1 with sel=0; COUNT write coinciding with a tick.
  - Required: rdata=0 with sel deasserted. The written value is held exactly and the tick is lost; pcnt restarts from 0.

Source files
------------

// File: rtl/timer_bank.sv
// rtl/timer_bank.sv - bank of NCH prescaled timers with W1C pending flags and a masked irq
module timer_bank #(
    parameter int WIDTH = 16,
    parameter int NCH   = 2,
    parameter int PSW   = 8,
    parameter int AW    = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sel,
    input  logic [AW-1:0]    addr,
    input  logic             rd,
    input  logic             wr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             irq,
    output logic [NCH-1:0]   pending
);

    localparam int CW = AW - 2;

    localparam logic [1:0] REG_COUNT    = 2'd0;
    localparam logic [1:0] REG_COMPARE  = 2'd1;
    localparam logic [1:0] REG_CTRL     = 2'd2;
    localparam logic [1:0] REG_PRESCALE = 2'd3;

    localparam logic [1:0] REG_STATUS   = 2'd0;
    localparam logic [1:0] REG_IEALL    = 2'd1;

    localparam logic [1:0] MODE_PERIODIC = 2'd1;
    localparam logic [1:0] MODE_ONESHOT  = 2'd2;

    logic [CW-1:0] ch;
    logic [1:0]    rsel;
    logic          wr_en;
    logic          rd_en;
    logic          status_wr;

    assign ch        = addr[AW-1:2];
    assign rsel      = addr[1:0];
    assign wr_en     = sel & wr;
    assign rd_en     = sel & rd;
    assign status_wr = wr_en && (ch == CW'(NCH)) && (rsel == REG_STATUS);

    logic [NCH-1:0][WIDTH-1:0] count_q, count_d;
    logic [NCH-1:0][WIDTH-1:0] cmp_q, cmp_d;
    logic [NCH-1:0][PSW-1:0]   psc_q, psc_d;
    logic [NCH-1:0][PSW-1:0]   pcnt_q, pcnt_d;
    logic [NCH-1:0][1:0]       mode_q, mode_d;
    logic [NCH-1:0]            en_q, en_d;
    logic [NCH-1:0]            ie_q, ie_d;
    logic [NCH-1:0]            pend_q, pend_d;
    logic                      irq_q, irq_d;
    logic [NCH-1:0]            tick;
    logic [NCH-1:0]            evt;

    // Per-channel prescaler, counter and register writes; a bus write is
    // applied last so it overrides the same-cycle tick.
    always_comb begin
        count_d = count_q;
        cmp_d   = cmp_q;
        psc_d   = psc_q;
        pcnt_d  = pcnt_q;
        mode_d  = mode_q;
        en_d    = en_q;
        ie_d    = ie_q;
        tick    = '0;
        evt     = '0;
        for (int c = 0; c < NCH; c++) begin
            tick[c] = en_q[c] && (pcnt_q[c] == psc_q[c]);
            if (en_q[c]) begin
                pcnt_d[c] = tick[c] ? '0 : pcnt_q[c] + 1'b1;
            end
            if (tick[c]) begin
                if (mode_q[c] == MODE_PERIODIC || mode_q[c] == MODE_ONESHOT) begin
                    if (count_q[c] == cmp_q[c]) begin
                        count_d[c] = '0;
                        evt[c]     = 1'b1;
                        if (mode_q[c] == MODE_ONESHOT) begin
                            en_d[c] = 1'b0;
                        end
                    end else begin
                        count_d[c] = count_q[c] + 1'b1;
                    end
                end else begin
                    count_d[c] = count_q[c] + 1'b1;
                    evt[c]     = &count_q[c];
                end
            end
            if (wr_en && (ch == CW'(c))) begin
                case (rsel)
                    REG_COUNT: begin
                        count_d[c] = wdata;
                        pcnt_d[c]  = '0;
                    end
                    REG_COMPARE: cmp_d[c] = wdata;
                    REG_CTRL: begin
                        en_d[c]   = wdata[0];
                        mode_d[c] = wdata[2:1];
                        ie_d[c]   = wdata[3];
                        if (wdata[0] && !en_q[c]) begin
                            pcnt_d[c] = '0;
                        end
                    end
                    default: psc_d[c] = wdata[PSW-1:0];
                endcase
            end
        end
    end

    // A clear racing an event on the same channel loses: the set is ORed in last.
    always_comb begin
        pend_d = pend_q;
        if (status_wr) begin
            pend_d = pend_q & ~wdata[NCH-1:0];
        end
        pend_d = pend_d | evt;
        irq_d  = |(pend_q & ie_q);
    end

    always_comb begin
        rdata = '0;
        if (rd_en) begin
            if (ch == CW'(NCH)) begin
                case (rsel)
                    REG_STATUS: rdata[NCH-1:0] = pend_q;
                    REG_IEALL:  rdata[NCH-1:0] = ie_q;
                    default:    rdata = '0;
                endcase
            end else begin
                for (int c = 0; c < NCH; c++) begin
                    if (ch == CW'(c)) begin
                        case (rsel)
                            REG_COUNT:   rdata = count_q[c];
                            REG_COMPARE: rdata = cmp_q[c];
                            REG_CTRL:    rdata[3:0] = {ie_q[c], mode_q[c], en_q[c]};
                            default:     rdata[PSW-1:0] = psc_q[c];
                        endcase
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
            cmp_q   <= '0;
            psc_q   <= '0;
            pcnt_q  <= '0;
            mode_q  <= '0;
            en_q    <= '0;
            ie_q    <= '0;
            pend_q  <= '0;
            irq_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            cmp_q   <= cmp_d;
            psc_q   <= psc_d;
            pcnt_q  <= pcnt_d;
            mode_q  <= mode_d;
            en_q    <= en_d;
            ie_q    <= ie_d;
            pend_q  <= pend_d;
            irq_q   <= irq_d;
        end
    end

    assign irq     = irq_q;
    assign pending = pend_q;

endmodule

// File: tb/tb_timer_bank.sv
// tb/tb_timer_bank.sv - directed self-checking bench for timer_bank
module tb_timer_bank;

    localparam int WIDTH = 16;
    localparam int NCH   = 2;
    localparam int PSW   = 8;
    localparam int AW    = 5;

    logic             clk;
    logic             reset;
    logic             sel;
    logic [AW-1:0]    addr;
    logic             rd;
    logic             wr;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] rdata;
    logic             irq;
    logic [NCH-1:0]   pending;

    int n_vec = 0;
    int n_err = 0;

    timer_bank #(.WIDTH(WIDTH), .NCH(NCH), .PSW(PSW), .AW(AW)) dut (
        .clk     (clk),
        .reset   (reset),
        .sel     (sel),
        .addr    (addr),
        .rd      (rd),
        .wr      (wr),
        .wdata   (wdata),
        .rdata   (rdata),
        .irq     (irq),
        .pending (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
        end
    endtask

    // Drive at a falling edge, hold across one rising edge, release at the next falling edge.
    task automatic wr_reg(input int c, input int r, input logic [WIDTH-1:0] d);
        addr  = AW'(c * 4 + r);
        wdata = d;
        sel   = 1'b1;
        wr    = 1'b1;
        @(negedge clk);
        sel   = 1'b0;
        wr    = 1'b0;
    endtask

    task automatic rd_reg(input int c, input int r, output logic [WIDTH-1:0] d);
        addr = AW'(c * 4 + r);
        sel  = 1'b1;
        rd   = 1'b1;
        #1;
        d    = rdata;
        sel  = 1'b0;
        rd   = 1'b0;
    endtask

    task automatic chk_reg(input string tag, input int c, input int r, input logic [WIDTH-1:0] exp);
        logic [WIDTH-1:0] v;
        rd_reg(c, r, v);
        chk(tag, v, exp);
    endtask

    initial begin
        int seq[4];
        seq = '{1, 2, 3, 0};
        reset = 1'b1;
        sel   = 1'b0;
        rd    = 1'b0;
        wr    = 1'b0;
        addr  = '0;
        wdata = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // reset state and readback
        for (int c = 0; c <= NCH; c++) begin
            for (int r = 0; r < 4; r++) begin
                chk_reg($sformatf("rst_c%0d_r%0d", c, r), c, r, 0);
            end
        end
        chk("rst_irq", WIDTH'(irq), 0);
        chk("rst_pend", WIDTH'(pending), 0);
        wr_reg(0, 1, 'h1234);
        chk_reg("rb_cmp", 0, 1, 'h1234);
        wr_reg(0, 3, 'h01FF);
        chk_reg("rb_psc", 0, 3, 'h00FF);

        // free-run wrap on ch0
        wr_reg(0, 3, 0);
        wr_reg(0, 0, 'hFFFD);
        wr_reg(0, 2, 'h9);
        chk_reg("fr_cnt0", 0, 0, 'hFFFD);
        @(negedge clk);
        chk_reg("fr_cnt1", 0, 0, 'hFFFE);
        @(negedge clk);
        chk_reg("fr_cnt2", 0, 0, 'hFFFF);
        chk("fr_pend_pre", WIDTH'(pending), 0);
        @(negedge clk);
        chk_reg("fr_cnt3", 0, 0, 'h0000);
        chk("fr_pend", WIDTH'(pending), 1);
        chk("fr_irq_lag", WIDTH'(irq), 0);
        @(negedge clk);
        chk("fr_irq", WIDTH'(irq), 1);
        wr_reg(0, 2, 0);
        wr_reg(NCH, 0, 1);
        chk("fr_clr_pend", WIDTH'(pending), 0);
        chk("fr_clr_irq", WIDTH'(irq), 0);

        // periodic with prescaler on ch1, IE off
        wr_reg(1, 1, 3);
        wr_reg(1, 3, 2);
        wr_reg(1, 2, 'h3);
        for (int k = 0; k < 4; k++) begin
            repeat (3) @(negedge clk);
            chk_reg($sformatf("per_cnt%0d", k), 1, 0, WIDTH'(seq[k]));
            if (k == 2) chk("per_pend_pre", WIDTH'(pending), 0);
        end
        chk("per_pend", WIDTH'(pending), 'h2);
        wr_reg(NCH, 0, 2);
        repeat (10) @(negedge clk);
        chk("per_pend_gap", WIDTH'(pending), 0);
        @(negedge clk);
        chk("per_pend_12", WIDTH'(pending), 'h2);
        chk("per_irq", WIDTH'(irq), 0);
        wr_reg(1, 2, 0);
        wr_reg(NCH, 0, 2);

        // one-shot on ch0
        wr_reg(0, 0, 0);
        wr_reg(0, 1, 5);
        wr_reg(0, 2, 'hD);
        repeat (5) @(negedge clk);
        chk_reg("os_cnt5", 0, 0, 5);
        chk("os_pend_pre", WIDTH'(pending), 0);
        @(negedge clk);
        chk("os_pend", WIDTH'(pending), 1);
        chk_reg("os_ctrl", 0, 2, 'hC);
        chk_reg("os_cnt", 0, 0, 0);
        chk_reg("os_ieall", NCH, 1, 1);
        repeat (20) @(negedge clk);
        chk_reg("os_hold", 0, 0, 0);
        chk("os_irq", WIDTH'(irq), 1);
        wr_reg(NCH, 0, 1);
        chk("os_clr_pend", WIDTH'(pending), 0);
        chk("os_clr_irq_lag", WIDTH'(irq), 1);
        @(negedge clk);
        chk("os_clr_irq", WIDTH'(irq), 0);

        // W1C racing an event on ch0
        wr_reg(0, 0, 0);
        wr_reg(0, 1, 2);
        wr_reg(0, 2, 'hB);
        @(negedge clk);
        @(negedge clk);
        wr_reg(NCH, 0, 1);
        chk("race_pend", WIDTH'(pending), 1);
        wr_reg(0, 2, 'h8);
        chk("race_irq", WIDTH'(irq), 1);
        chk_reg("race_ieall", NCH, 1, 1);
        wr_reg(NCH, 0, 1);
        chk("race_clr_pend", WIDTH'(pending), 0);
        chk("race_irq_lag", WIDTH'(irq), 1);
        @(negedge clk);
        chk("race_irq_drop", WIDTH'(irq), 0);

        // bus isolation and rd/wr overlap
        addr = AW'(0);
        sel  = 1'b0;
        rd   = 1'b1;
        #1;
        chk("iso_nosel", rdata, 0);
        rd   = 1'b0;
        chk_reg("iso_unmapped", 3, 1, 0);
        addr  = AW'(1);
        wdata = 'h77;
        sel   = 1'b1;
        rd    = 1'b1;
        wr    = 1'b1;
        #1;
        chk("rdwr_old", rdata, 2);
        @(negedge clk);
        sel = 1'b0;
        rd  = 1'b0;
        wr  = 1'b0;
        chk_reg("rdwr_new", 0, 1, 'h77);

        // COUNT write colliding with a tick, then pcnt restart
        wr_reg(1, 3, 2);
        wr_reg(1, 0, 'h10);
        wr_reg(1, 2, 'h1);
        @(negedge clk);
        @(negedge clk);
        wr_reg(1, 0, 'h100);
        chk_reg("cw_tick_lost", 1, 0, 'h100);
        @(negedge clk);
        wr_reg(1, 0, 'h200);
        @(negedge clk);
        chk_reg("cw_pcnt_a", 1, 0, 'h200);
        @(negedge clk);
        chk_reg("cw_pcnt_b", 1, 0, 'h200);
        @(negedge clk);
        chk_reg("cw_pcnt_c", 1, 0, 'h201);

        // reset mid-count
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk_reg("mrst_cnt", 1, 0, 0);
        chk_reg("mrst_ctrl", 1, 2, 0);
        chk("mrst_pend", WIDTH'(pending), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
